// File: rtl/ram_fifo_pkg.sv
// Shared definitions for the RAM-backed stream FIFO: default widths and
// helpers for counter sizing and pointer wrap.
package ram_fifo_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 7;
   localparam int AF_LVL_DEF = 120;

   // Bits needed to represent every value 0..depth inclusive.
   function automatic int lvl_w(input int depth);
      int w;
      w = 1;
      for (int i = 0; i < 31; i++) begin
         if ((depth >> i) != 0) w = i + 1;
      end
      return w;
   endfunction

   function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int aw);
      logic [31:0] mask;
      mask = (32'd1 << aw) - 32'd1;
      return (ptr + 32'd1) & mask;
   endfunction

endpackage

// File: rtl/ram_fifo_dpram.sv
// Simple dual-port RAM: synchronous write, registered read address and
// asynchronous read from it, which makes same-address read/write write-first.
module ram_fifo_dpram
   import ram_fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [0:DEPTH-1];
   logic [ADDR_W-1:0] rd_addr_q;

   always_ff @(posedge clk) begin
      if (we) mem_q[wr_addr] <= wr_data;
      rd_addr_q <= rd_addr;
   end

   assign rd_data = mem_q[rd_addr_q];

endmodule

// File: rtl/ram_stream_fifo.sv
// Valid/ready stream FIFO around ram_fifo_dpram. Optional occupancy outputs
// (level, almost_full) are built when FIFO_LEVEL_EN is defined.
module ram_stream_fifo
   import ram_fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
`ifdef FIFO_LEVEL_EN
   ,
   parameter int AF_LVL = AF_LVL_DEF
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
`ifdef FIFO_LEVEL_EN
   ,
   output logic [ADDR_W:0]   level,
   output logic              almost_full
`endif
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CNT_W = lvl_w(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [ADDR_W-1:0] ram_rd_addr;
   logic              push, pop;

   // Handshake: a transfer happens on a side exactly when valid and ready are
   // both high at the rising edge; ready/valid outputs are registered.
   assign push = in_valid & in_ready_q;
   assign pop  = out_valid_q & out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = ADDR_W'(ptr_inc(32'(wr_ptr_q), ADDR_W));
      if (pop)  rd_ptr_d = ADDR_W'(ptr_inc(32'(rd_ptr_q), ADDR_W));
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      in_ready_d  = (count_d != DEPTH_C);
      out_valid_d = (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   // The RAM read address tracks the next head so out_data is ready with the flag.
   assign ram_rd_addr = rst ? '0 : rd_ptr_d;

   ram_fifo_dpram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .we      (push & ~rst),
      .wr_addr (wr_ptr_q),
      .wr_data (in_data),
      .rd_addr (ram_rd_addr),
      .rd_data (out_data)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;

`ifdef FIFO_LEVEL_EN
   logic [ADDR_W:0] level_q;
   logic            almost_full_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         level_q       <= '0;
         almost_full_q <= 1'b0;
      end else begin
         level_q       <= count_d;
         almost_full_q <= (count_d >= CNT_W'(AF_LVL));
      end
   end

   assign level       = level_q;
   assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_ram_stream_fifo.sv
// Self-checking bench for ram_stream_fifo against a queue-based reference
// model; level/almost_full checks are compiled in with FIFO_LEVEL_EN.
module tb_ram_stream_fifo;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 128;
   localparam int AF_LVL = 120;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
`ifdef FIFO_LEVEL_EN
   logic [7:0]        level;
   logic              almost_full;
`endif

   logic [DATA_W-1:0] exp_q[$];
   int                chk_cnt;
   int                pass_cnt;

   ram_stream_fifo dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef FIFO_LEVEL_EN
      ,
      .level       (level),
      .almost_full (almost_full)
`endif
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One clock of stimulus; the model accepts a push only when not full and a
   // pop only when not empty, judged on the occupancy before the edge.
   task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r);
      logic m_push, m_pop;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      m_push = v && (exp_q.size() < DEPTH);
      m_pop  = r && (exp_q.size() != 0);
      @(posedge clk);
      #1;
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(d);
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic do_reset(input logic v, input logic r);
      rst       = 1'b1;
      in_valid  = v;
      out_ready = r;
      in_data   = DATA_W'($urandom);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      do_reset(1'b0, 1'b0);
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b1);
      chk_cnt++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready);
      else pass_cnt++;
      chk_cnt++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid);
      else pass_cnt++;
`ifdef FIFO_LEVEL_EN
      chk_cnt++;
      if (level !== 8'd0) $display("FAIL reset_level got %0d exp 0", level);
      else pass_cnt++;
      chk_cnt++;
      if (almost_full !== 1'b0) $display("FAIL reset_almost_full got %b exp 0", almost_full);
      else pass_cnt++;
`endif
   endtask

   task automatic test_single();
      step(1'b1, 16'hA5A5, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk_cnt++;
         if (out_valid !== 1'b1) $display("FAIL single_valid cyc %0d got %b exp 1", i, out_valid);
         else pass_cnt++;
         chk_cnt++;
         if (out_data !== 16'hA5A5) $display("FAIL single_data cyc %0d got %h exp a5a5", i, out_data);
         else pass_cnt++;
         step(1'b0, '0, 1'b0);
      end
      step(1'b0, '0, 1'b1);
      chk_cnt++;
      if (out_valid !== 1'b0) $display("FAIL single_empty got %b exp 0", out_valid);
      else pass_cnt++;
   endtask

   task automatic test_fill();
      do_reset(1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'(i), 1'b0);
      chk_cnt++;
      if (in_ready !== 1'b0) $display("FAIL full_in_ready got %b exp 0", in_ready);
      else pass_cnt++;
      step(1'b1, 16'hDEAD, 1'b0);
      chk_cnt++;
      if (in_ready !== 1'b0) $display("FAIL full_hold_ready got %b exp 0", in_ready);
      else pass_cnt++;
      // pop while full, with a push attempt that must be refused
      step(1'b1, 16'hBEEF, 1'b1);
      chk_cnt++;
      if (in_ready !== 1'b1) $display("FAIL full_ready_after_pop got %b exp 1", in_ready);
      else pass_cnt++;
      for (int i = 1; i < DEPTH; i++) begin
         chk_cnt++;
         if (out_valid !== 1'b1 || out_data !== DATA_W'(i))
            $display("FAIL full_drain idx %0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, DATA_W'(i));
         else pass_cnt++;
         step(1'b0, '0, 1'b1);
      end
      chk_cnt++;
      if (out_valid !== 1'b0) $display("FAIL full_drain_empty got %b exp 0", out_valid);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] d;
      do_reset(1'b0, 1'b0);
      step(1'b1, DATA_W'($urandom), 1'b0);
      for (int i = 0; i < 300; i++) begin
         chk_cnt++;
         if (out_valid !== 1'b1 || out_data !== exp_q[0])
            $display("FAIL stream cyc %0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exp_q[0]);
         else pass_cnt++;
`ifdef FIFO_LEVEL_EN
         chk_cnt++;
         if (level !== 8'd1) $display("FAIL stream_level cyc %0d got %0d exp 1", i, level);
         else pass_cnt++;
`endif
         d = DATA_W'($urandom);
         step(1'b1, d, 1'b1);
      end
      chk_cnt++;
      if (out_data !== exp_q[0]) $display("FAIL stream_last got %h exp %h", out_data, exp_q[0]);
      else pass_cnt++;
      step(1'b0, '0, 1'b1);
      chk_cnt++;
      if (out_valid !== 1'b0) $display("FAIL stream_empty got %b exp 0", out_valid);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      do_reset(1'b0, 1'b0);
      for (int i = 0; i < 50; i++) step(1'b1, DATA_W'($urandom), 1'b0);
      chk_cnt++;
      if (out_valid !== 1'b1) $display("FAIL mid_prefill_valid got %b exp 1", out_valid);
      else pass_cnt++;
      do_reset(1'b1, 1'b1);
      chk_cnt++;
      if (out_valid !== 1'b0) $display("FAIL mid_out_valid got %b exp 0", out_valid);
      else pass_cnt++;
      chk_cnt++;
      if (in_ready !== 1'b1) $display("FAIL mid_in_ready got %b exp 1", in_ready);
      else pass_cnt++;
`ifdef FIFO_LEVEL_EN
      chk_cnt++;
      if (level !== 8'd0) $display("FAIL mid_level got %0d exp 0", level);
      else pass_cnt++;
`endif
      step(1'b1, 16'h1234, 1'b0);
      chk_cnt++;
      if (out_valid !== 1'b1 || out_data !== 16'h1234)
         $display("FAIL mid_first_word got v=%b d=%h exp v=1 d=1234", out_valid, out_data);
      else pass_cnt++;
      step(1'b0, '0, 1'b1);
      chk_cnt++;
      if (out_valid !== 1'b0) $display("FAIL mid_drain got %b exp 0", out_valid);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int pv, pr;
      logic exp_rdy, exp_vld;
      do_reset(1'b0, 1'b0);
      for (int i = 0; i < 1800; i++) begin
         if (i < 700)       begin pv = 90; pr = 20; end
         else if (i < 1300) begin pv = 20; pr = 90; end
         else               begin pv = 60; pr = 60; end
         exp_rdy = (exp_q.size() != DEPTH);
         exp_vld = (exp_q.size() != 0);
         chk_cnt++;
         if (in_ready !== exp_rdy) $display("FAIL rnd_in_ready cyc %0d got %b exp %b", i, in_ready, exp_rdy);
         else pass_cnt++;
         chk_cnt++;
         if (out_valid !== exp_vld) $display("FAIL rnd_out_valid cyc %0d got %b exp %b", i, out_valid, exp_vld);
         else pass_cnt++;
         if (exp_vld) begin
            chk_cnt++;
            if (out_data !== exp_q[0]) $display("FAIL rnd_data cyc %0d got %h exp %h", i, out_data, exp_q[0]);
            else pass_cnt++;
         end
`ifdef FIFO_LEVEL_EN
         chk_cnt++;
         if (level !== 8'(exp_q.size()) || almost_full !== (exp_q.size() >= AF_LVL))
            $display("FAIL rnd_level cyc %0d got %0d/%b exp %0d", i, level, almost_full, exp_q.size());
         else pass_cnt++;
`endif
         step(($urandom_range(0, 99) < pv), DATA_W'($urandom), ($urandom_range(0, 99) < pr));
      end
   endtask

`ifdef FIFO_LEVEL_EN
   task automatic test_level();
      do_reset(1'b0, 1'b0);
      for (int i = 0; i < AF_LVL - 1; i++) step(1'b1, DATA_W'($urandom), 1'b0);
      chk_cnt++;
      if (almost_full !== 1'b0 || level !== 8'd119)
         $display("FAIL lvl_119 got af=%b lvl=%0d exp af=0 lvl=119", almost_full, level);
      else pass_cnt++;
      step(1'b1, DATA_W'($urandom), 1'b0);
      chk_cnt++;
      if (almost_full !== 1'b1 || level !== 8'd120)
         $display("FAIL lvl_120 got af=%b lvl=%0d exp af=1 lvl=120", almost_full, level);
      else pass_cnt++;
      step(1'b0, '0, 1'b1);
      chk_cnt++;
      if (almost_full !== 1'b0 || level !== 8'd119)
         $display("FAIL lvl_pop got af=%b lvl=%0d exp af=0 lvl=119", almost_full, level);
      else pass_cnt++;
   endtask
`endif

   initial begin
      chk_cnt   = 0;
      pass_cnt  = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_fill();
      test_back_to_back();
      test_reset_mid();
      test_random();
`ifdef FIFO_LEVEL_EN
      test_level();
`endif
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
